// File: rtl/ccl_code_builder.sv
// Canonical Huffman code builder for the ten 3-bit code-length symbols.
// Counts lengths, derives first codes with a Kraft check, then assigns codes.

module ccl_sym_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] len_in,
  input  logic       wr,
  input  logic [6:0] code_in,
  output logic [2:0] len,
  output logic [6:0] code
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len  <= '0;
      code <= '0;
    end else if (load) begin
      len  <= len_in;
      code <= '0;
    end else if (wr) begin
      code <= code_in;
    end
  end
endmodule

module ccl_code_builder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [29:0] CCL_sq,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [3:0]  rd_sym,
  output logic [2:0]  rd_len,
  output logic [6:0]  rd_code
);
  localparam int NUM_SYM = 10;

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_NEXT, S_ASSIGN, S_DONE} state_t;

  state_t state, nxt;
  logic [3:0]                 cnt;
  logic [NUM_SYM-1:0][2:0]    sym_len;
  logic [NUM_SYM-1:0][6:0]    sym_code;
  logic [7:0][3:0]            bl_count;   // entry 0 is never incremented
  logic [7:1][6:0]            next_code;
  logic [6:0]                 code_acc;
  logic [8:0]                 left;       // two's complement Kraft remainder
  logic                       accept;
  logic [2:0]                 cur_len, bidx, bm1;
  logic [6:0]                 sum7, code_step;
  logic [8:0]                 left_step;

  assign accept  = (state == S_IDLE) && start;
  assign cur_len = (cnt <= 4'd9) ? sym_len[cnt] : 3'd0;
  assign bidx    = cnt[2:0];
  assign bm1     = bidx - 3'd1;
  assign sum7      = code_acc + 7'(bl_count[bm1]);
  assign code_step = 7'({sum7, 1'b0});
  assign left_step = 9'({left, 1'b0}) - 9'(bl_count[bidx]);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start)        nxt = S_COUNT;
      S_COUNT:  if (cnt == 4'd9)  nxt = S_NEXT;
      S_NEXT:   if (cnt == 4'd7)  nxt = S_ASSIGN;
      S_ASSIGN: if (cnt == 4'd9)  nxt = S_DONE;
      S_DONE:                     nxt = S_IDLE;
      default:                    nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_COUNT, S_NEXT, S_ASSIGN: busy = 1'b1;
      S_DONE:                    done = 1'b1;
      default: ;
    endcase
  end

  // datapath: length histogram, first-code recurrence, Kraft check, code counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bl_count  <= '0;
      next_code <= '0;
      code_acc  <= '0;
      left      <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            bl_count <= '0;
            err      <= 1'b0;
          end
        end
        S_COUNT: begin
          if (cur_len != 3'd0) bl_count[cur_len] <= bl_count[cur_len] + 4'd1;
          if (cnt == 4'd9) begin
            cnt      <= 4'd1;
            code_acc <= '0;
            left     <= 9'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_NEXT: begin
          code_acc        <= code_step;
          next_code[bidx] <= code_step;
          left            <= left_step;
          if (left_step[8]) err <= 1'b1;
          cnt <= (cnt == 4'd7) ? 4'd0 : cnt + 4'd1;
        end
        S_ASSIGN: begin
          if (cur_len != 3'd0) next_code[cur_len] <= next_code[cur_len] + 7'd1;
          cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SYM; i++) begin : g_slot
    logic wr;
    assign wr = (state == S_ASSIGN) && (cnt == 4'(i)) && (sym_len[i] != 3'd0);
    ccl_sym_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .len_in  (CCL_sq[3*i +: 3]),
      .wr      (wr),
      .code_in (next_code[sym_len[i]]),
      .len     (sym_len[i]),
      .code    (sym_code[i])
    );
  end

  assign rd_len  = (rd_sym <= 4'd9) ? sym_len[rd_sym]  : 3'd0;
  assign rd_code = (rd_sym <= 4'd9) ? sym_code[rd_sym] : 7'd0;
endmodule

// File: tb/tb_ccl_code_builder.sv
// Directed table-driven bench for ccl_code_builder, plus start re-pulse and mid-build reset sequences.

module tb_ccl_code_builder;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [29:0] CCL_sq = '0;
  logic [3:0]  rd_sym = '0;
  logic        busy, done, err;
  logic [2:0]  rd_len;
  logic [6:0]  rd_code;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ccl_code_builder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .CCL_sq(CCL_sq),
    .busy(busy), .done(done), .err(err),
    .rd_sym(rd_sym), .rd_len(rd_len), .rd_code(rd_code)
  );

  typedef struct {
    logic [29:0] ccl;
    logic [69:0] codes;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];
  vec_t zero_v;

  function automatic logic [29:0] pk(input int l0, l1, l2, l3, l4, l5, l6, l7, l8, l9);
    return {3'(l9), 3'(l8), 3'(l7), 3'(l6), 3'(l5), 3'(l4), 3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  function automatic logic [69:0] cpk(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9);
    return {7'(c9), 7'(c8), 7'(c7), 7'(c6), 7'(c5), 7'(c4), 7'(c3), 7'(c2), 7'(c1), 7'(c0)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic check_table(input string tag, input vec_t v);
    for (int s = 0; s < 10; s++) begin
      rd_sym = 4'(s);
      #1;
      chk($sformatf("%s len[%0d]", tag, s), int'(rd_len), int'(v.ccl[3*s +: 3]));
      chk($sformatf("%s code[%0d]", tag, s), int'(rd_code), int'(v.codes[7*s +: 7]));
    end
  endtask

  task automatic run_build(input string tag, input vec_t v, input logic [29:0] alt,
                           input int repulse_at, input int rst_at);
    int done_cyc = 0;
    bit busy_ok  = 1'b1;
    logic err_at_done = 1'b0;
    @(negedge clk);
    CCL_sq = v.ccl;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    CCL_sq = ~v.ccl;
    for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == repulse_at + 1) start = 1'b0;
      if (k == repulse_at) begin start = 1'b1; CCL_sq = alt; end
      if (done && done_cyc == 0) begin done_cyc = k; err_at_done = err; end
      if (k <= 27 && busy !== 1'b1) busy_ok = 1'b0;
      if (k == 28 && busy !== 1'b0) busy_ok = 1'b0;
      if (k == rst_at) begin
        chk({tag, " err before reset"}, int'(err), 1);
        rst_n = 1'b0;
        #1;
        chk({tag, " busy in reset"}, int'(busy), 0);
        chk({tag, " done in reset"}, int'(done), 0);
        chk({tag, " err in reset"}, int'(err), 0);
        check_table({tag, " in reset"}, zero_v);
        return;
      end
    end
    chk({tag, " done cycle"}, done_cyc, 28);
    chk({tag, " busy window"}, int'(busy_ok), 1);
    chk({tag, " err at done"}, int'(err_at_done), int'(v.exp_err));
    @(posedge clk);
    #1;
    chk({tag, " done one cycle"}, int'(done), 0);
    chk({tag, " busy after done"}, int'(busy), 0);
    chk({tag, " err held"}, int'(err), int'(v.exp_err));
    check_table(tag, v);
  endtask

  initial begin
    zero_v  = '{30'd0, 70'd0, 1'b0};
    tbl[0] = '{pk(3,3,3,3,3,2,4,4,0,0), cpk(2,3,4,5,6,0,14,15,0,0), 1'b0};
    tbl[1] = '{pk(0,0,0,0,0,0,0,0,0,0), cpk(0,0,0,0,0,0,0,0,0,0), 1'b0};
    tbl[2] = '{pk(1,1,1,0,0,0,0,0,0,0), cpk(0,1,2,0,0,0,0,0,0,0), 1'b1};
    tbl[3] = '{pk(3,3,3,3,3,2,4,4,0,0), cpk(2,3,4,5,6,0,14,15,0,0), 1'b0};
    tbl[4] = '{pk(0,0,0,0,0,1,0,0,0,0), cpk(0,0,0,0,0,0,0,0,0,0), 1'b0};
    tbl[5] = '{pk(4,4,4,4,4,4,4,4,4,4), cpk(0,1,2,3,4,5,6,7,8,9), 1'b0};
    tbl[6] = '{pk(1,2,3,4,5,6,7,7,0,0), cpk(0,2,6,14,30,62,126,127,0,0), 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    check_table("reset", zero_v);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_build($sformatf("vec%0d", i), tbl[i], 30'd0, 0, 0);

    // start pulsed again during COUNT with a different vector must be ignored
    run_build("repulse", tbl[0], tbl[5].ccl, 3, 0);

    rd_sym = 4'd12;
    #1;
    chk("rd_sym12 len", int'(rd_len), 0);
    chk("rd_sym12 code", int'(rd_code), 0);
    rd_sym = 4'd15;
    #1;
    chk("rd_sym15 len", int'(rd_len), 0);
    chk("rd_sym15 code", int'(rd_code), 0);

    // oversubscribed build interrupted by reset in ASSIGN, then a clean rebuild
    run_build("midreset", tbl[2], 30'd0, 0, 20);
    @(negedge clk);
    rst_n = 1'b1;
    run_build("after_reset", tbl[0], 30'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccl_code_builder.md
# ccl_code_builder

Downstream of the byte buffer stage: consumes the packed 30-bit code-length sequence `CCL_sq` (ten 3-bit code lengths) once all four bytes have been loaded. It builds the canonical Huffman code for those ten symbols, following the DEFLATE canonical rule. It publishes a per-symbol {length, code} table through a combinational read port for the symbol decoder that follows.

## Interface
- No parameters (symbol count 10, max length 7 fixed by the `CCL_sq` format).
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; `CCL_sq` must be stable in that cycle only
- `CCL_sq`  in  30  symbol i length = `CCL_sq[3i+2:3i]`, i = 0..9; 0 = unused
- `busy`  out  1  high while building
- `done`  out  1  one-cycle pulse when table valid
- `err`  out  1  lengths oversubscribed (Kraft sum > 1); sticky until next accepted start
- `rd_sym`  in  4  table read index
- `rd_len`  out  3  stored length of `rd_sym`
- `rd_code`  out  7  canonical code of `rd_sym`, right-aligned, MSB-first transmission order

## Operation
- Reset: state IDLE, `busy`=0, `done`=0, `err`=0, all lengths/codes/counters 0.
- Reset is honoured in every state, including mid-build; the build is abandoned and nothing resumes.
- Read port: purely combinational from registers.
  - `rd_sym` > 9 returns `rd_len`=0, `rd_code`=0.
  - Table contents are only guaranteed from the `done` cycle onward.
- FSM states: IDLE -> COUNT -> NEXT -> ASSIGN -> DONE -> IDLE.
- IDLE:
  - `start`=1: latch `CCL_sq` into ten length registers, clear code regs, `bl_count[1..7]`, `err`; go to COUNT.
  - `start` is accepted only in IDLE and ignored in every other state.
- COUNT, 10 cycles, sym 0..9: if len != 0, `bl_count[len]`++ (4-bit counters).
- NEXT, 7 cycles, bits 1..7; `code` and `left` both start at 0/1 and are initialised on entry:
  - Code recurrence: `code` = (`code` + `bl_count[bits-1]`) << 1, with `bl_count[0]`=0; `next_code[bits]` = `code`.
  - Kraft check: `left` (signed, 9-bit) starts at 1; each step `left` = 2*`left` - `bl_count[bits]`.
  - `left` < 0 at any step sets `err`.
- ASSIGN, 10 cycles, sym 0..9: if len != 0, `code[sym]` = `next_code[len]` and `next_code[len]`++.
  - Arithmetic is mod 2^7. On overflow (oversubscribed input only) codes wrap and are meaningless, with `err`=1.
  - Symbols with len 0 keep code 0.
- DONE, 1 cycle: `done`=1, `busy`=0; then IDLE.
- Incomplete codes (Kraft sum < 1, including a single length-1 symbol or all-zero input) are legal: `err`=0.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- `busy`=1 from the cycle after E0 for exactly 27 cycles (COUNT 10 + NEXT 7 + ASSIGN 10).
- `done`=1 in the 28th cycle after E0, for one cycle; `busy`=0 in that cycle.
- Earliest next accepted `start`: the cycle after `done` (IDLE).
- `err` is final by the first ASSIGN cycle and held stable through DONE and IDLE until the next accepted `start`.
- Table registers change only during ASSIGN (and on clear at E0+1), so reads are stable between builds.
- Asserting `rst_n`=0 asynchronously forces all outputs to their reset values immediately.

## Test plan
- Canonical example: lengths sym0..9 = 3,3,3,3,3,2,4,4,0,0 -> codes 010,011,100,101,110,00,1110,1111,0,0; `err`=0; `done` exactly 28 cycles after `start`; `busy` high for 27 cycles.
- All ten lengths 0 (`CCL_sq`=0) -> every `rd_len`/`rd_code` = 0, `err`=0, `done` still at cycle 28.
- Oversubscribed: sym0..2 = 1, rest 0 -> `err`=1 at `done`; a following valid build clears `err`.
- Incomplete codes:
  - Only sym5 = 1 -> `rd_code[5]`=0, `rd_len[5]`=1, `err`=0.
  - All ten = 4 -> codes 0000..1001 in symbol order, `err`=0.
- Control:
  - `start` re-pulsed during COUNT with different `CCL_sq` -> ignored, results match the first vector.
  - `rd_sym`=12 -> 0/0.
- Reset mid-ASSIGN -> `busy`, `done`, `err` and all table entries 0 immediately; a new `start` then completes normally in 28 cycles.
